motor_ramp_ctrl: RTL and testbench
==================================

Name: motor_ramp_ctrl

Overview:
- Sequences the 4-bit command word into the PWM motor driver.
- Accepts speed/direction targets from a host over a valid/ready handshake.
- Slews speed one level at a time at a fixed step rate, so the motor never jumps speed.
- On a direction reversal it ramps down to zero, waits a dead time, flips direction, then ramps back up.
- Sits between the host/command decoder and the PWM block, in the PWM clock domain.

Parameters:
- STEP_CYCLES, 100000, clk cycles between successive one-level speed changes (min 2).
- DEAD_CYCLES, 50000, clk cycles held at speed 0 before a direction flip (min 1).

Ports:
- clk  input  1  PWM-domain clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  host has a command on cmd_dir/cmd_spd.
- cmd_ready  output  1  block can accept a command.
- cmd_dir  input  1  target direction (0 = forward, 1 = reverse).
- cmd_spd  input  3  target speed level, 0 (stop) to 7 (max).
- estop  input  1  emergency stop, level-sensitive, synchronous to clk.
- pwm_data  output  4  {cur_dir, cur_spd[2:0]}; drives the PWM block data_in.
- busy  output  1  high whenever state is not STEADY.
- at_target  output  1  high when cur_dir==tgt_dir and cur_spd==tgt_spd and estop is low.

Behaviour:
- Reset (async, rst=1):
  - cur_dir=0, cur_spd=0, tgt_dir=0, tgt_spd=0.
  - state=STEADY, step_cnt=0, dead_cnt=0.
  - Outputs: pwm_data=4'h0, busy=0, at_target=1, cmd_ready=1.
- Handshake:
  - cmd_ready = ~estop.
  - A command is accepted on any rising edge with cmd_valid & cmd_ready; tgt_dir/tgt_spd load that edge.
  - Latest command wins; a command may be accepted in any state, including mid-ramp or in DEAD.
- States: STEADY, RAMP, DEAD.
- STEADY:
  - step_cnt held at 0.
  - If targets differ from current (checked each cycle, including the cycle after accept) -> RAMP.
  - Exception: cur_spd==0 and dir differs -> DEAD.
- RAMP:
  - step_cnt counts 0..STEP_CYCLES-1.
  - At step_cnt==STEP_CYCLES-1: step_cnt<=0 and one step is applied:
    - dir differs and cur_spd>0: cur_spd-1.
    - dir equal and cur_spd<tgt_spd: +1.
    - dir equal and cur_spd>tgt_spd: -1.
  - The first pwm_data change is exactly STEP_CYCLES cycles after entering RAMP.
  - Retarget mid-RAMP does not reset step_cnt; step direction is re-evaluated at each tick.
  - After a step, or any cycle where current==target: -> STEADY.
  - cur_spd==0 and dir differs: -> DEAD.
- DEAD:
  - cur_spd=0; dead_cnt counts 0..DEAD_CYCLES-1.
  - At terminal count: cur_dir<=tgt_dir, dead_cnt<=0.
  - Then -> RAMP if tgt_spd>0, else -> STEADY.
  - If a retarget in DEAD makes tgt_dir==cur_dir: leave DEAD immediately (next cycle) with no flip; -> RAMP or STEADY as above.
- estop=1:
  - Next edge: cur_spd<=0, tgt_spd<=0, state<=DEAD, dead_cnt<=0 (held at 0 while estop is high).
  - cur_dir and tgt_dir unchanged.
  - After estop falls: the full DEAD_CYCLES is counted, then STEADY at speed 0.
- Saturation and widths:
  - Speed arithmetic is 3-bit unsigned; a step never wraps below 0 or above 7.
  - Counters use clog2(STEP_CYCLES) and clog2(DEAD_CYCLES) bits.
- Output timing: pwm_data, busy and at_target are registered or derived only from registers (no input-to-output combinational path); cmd_ready is the exception, combinational from estop.

Test Plan:
Bench uses STEP_CYCLES=4, DEAD_CYCLES=3.
1. Reset, then command dir=0, spd=3.
   -> pwm_data steps 0x1, 0x2, 0x3 at 4-cycle spacing, the first 4 cycles after RAMP entry.
   -> busy falls the cycle after 0x3; at_target=1.
2. From 0x3, command dir=1, spd=2.
   -> pwm_data 0x2, 0x1, 0x0 at 4-cycle spacing.
   -> 3 cycles in DEAD, then cur_dir flips.
   -> pwm_data 0x9, then 0xA at 4-cycle spacing.
3. Mid-ramp retarget: ramping 0->5, at pwm_data=0x2 command spd=1.
   -> next tick gives 0x1 (step_cnt continuity checked), then STEADY.
4. estop pulse of 5 cycles while at 0xB.
   -> pwm_data=0x8 one cycle after estop rises.
   -> cmd_ready=0 during the pulse; a cmd_valid during the pulse is ignored.
   -> STEADY 3 cycles after estop falls; tgt_spd=0.
5. Async rst asserted mid-ramp, between clock edges.
   -> pwm_data=0x0, busy=0 immediately.
   -> after release, a new command ramps starting from 0.
6. Back-to-back commands on consecutive cycles (spd=7, then spd=2).
   -> only spd=2 takes effect; ramp stops at 0x2.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: sequences the 4-bit {dir, speed} command word for the PWM motor driver.
// A host loads speed/direction targets over a valid/ready handshake. The current speed slews
// one level every STEP_CYCLES clocks. A direction reversal ramps to zero, holds zero for
// DEAD_CYCLES clocks, flips direction and then ramps back up. estop forces speed 0 at once.
//
// Ports:
//   clk        PWM-domain clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  host command present on cmd_dir/cmd_spd
//   cmd_ready  command can be accepted (combinational: ~estop)
//   cmd_dir    target direction (0 fwd, 1 rev)
//   cmd_spd    target speed level 0..7
//   estop      emergency stop, level-sensitive, synchronous
//   pwm_data   {cur_dir, cur_spd} to the PWM block
//   busy       state is not STEADY
//   at_target  current equals target and no estop in force
module motor_ramp_ctrl #(
  parameter int unsigned STEP_CYCLES = 100000,
  parameter int unsigned DEAD_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [2:0] cmd_spd,
  input  logic       estop,
  output logic [3:0] pwm_data,
  output logic       busy,
  output logic       at_target
);

  localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [SW-1:0] StepLast = SW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DeadLast = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {StSteady, StRamp, StDead} state_e;

  state_e        state_q, state_d;
  logic          cur_dir_q, cur_dir_d;
  logic [2:0]    cur_spd_q, cur_spd_d;
  logic          tgt_dir_q, tgt_dir_d;
  logic [2:0]    tgt_spd_q, tgt_spd_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  // Set while DEAD was entered by estop: the full dead time must elapse even though
  // the directions already match, so the early-exit path is suppressed.
  logic          estop_dead_q, estop_dead_d;
  // Registered copy of estop keeps at_target free of an input-to-output path.
  logic          estop_q;

  logic accept;
  logic dir_diff;
  logic on_target;

  assign accept    = cmd_valid & ~estop;
  assign dir_diff  = cur_dir_q ^ tgt_dir_q;
  assign on_target = ~dir_diff & (cur_spd_q == tgt_spd_q);

  always_comb begin
    state_d      = state_q;
    cur_dir_d    = cur_dir_q;
    cur_spd_d    = cur_spd_q;
    tgt_dir_d    = tgt_dir_q;
    tgt_spd_d    = tgt_spd_q;
    step_cnt_d   = step_cnt_q;
    dead_cnt_d   = dead_cnt_q;
    estop_dead_d = estop_dead_q;

    if (accept) begin
      tgt_dir_d = cmd_dir;
      tgt_spd_d = cmd_spd;
    end

    if (estop) begin
      cur_spd_d    = 3'd0;
      tgt_spd_d    = 3'd0;
      state_d      = StDead;
      dead_cnt_d   = '0;
      step_cnt_d   = '0;
      estop_dead_d = 1'b1;
    end else begin
      unique case (state_q)
        StSteady: begin
          step_cnt_d = '0;
          if (dir_diff && (cur_spd_q == 3'd0)) begin
            state_d    = StDead;
            dead_cnt_d = '0;
          end else if (!on_target) begin
            state_d = StRamp;
          end
        end

        StRamp: begin
          if (dir_diff && (cur_spd_q == 3'd0)) begin
            state_d    = StDead;
            step_cnt_d = '0;
            dead_cnt_d = '0;
          end else if (on_target) begin
            state_d    = StSteady;
            step_cnt_d = '0;
          end else if (step_cnt_q == StepLast) begin
            // Stay in RAMP after a step so the next tick is exactly STEP_CYCLES later;
            // the following cycle drops to STEADY if the step landed on target.
            step_cnt_d = '0;
            if (dir_diff) begin
              cur_spd_d = cur_spd_q - 3'd1;  // cur_spd_q > 0 here
            end else if (cur_spd_q < tgt_spd_q) begin
              cur_spd_d = cur_spd_q + 3'd1;
            end else begin
              cur_spd_d = cur_spd_q - 3'd1;
            end
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end

        StDead: begin
          cur_spd_d = 3'd0;
          if (!estop_dead_q && !dir_diff) begin
            // Retarget cancelled the reversal: leave without flipping.
            dead_cnt_d = '0;
            state_d    = (tgt_spd_q != 3'd0) ? StRamp : StSteady;
          end else if (dead_cnt_q == DeadLast) begin
            cur_dir_d    = tgt_dir_q;
            dead_cnt_d   = '0;
            estop_dead_d = 1'b0;
            state_d      = (tgt_spd_q != 3'd0) ? StRamp : StSteady;
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = StSteady;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StSteady;
      cur_dir_q    <= 1'b0;
      cur_spd_q    <= 3'd0;
      tgt_dir_q    <= 1'b0;
      tgt_spd_q    <= 3'd0;
      step_cnt_q   <= '0;
      dead_cnt_q   <= '0;
      estop_dead_q <= 1'b0;
      estop_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_dir_q    <= cur_dir_d;
      cur_spd_q    <= cur_spd_d;
      tgt_dir_q    <= tgt_dir_d;
      tgt_spd_q    <= tgt_spd_d;
      step_cnt_q   <= step_cnt_d;
      dead_cnt_q   <= dead_cnt_d;
      estop_dead_q <= estop_dead_d;
      estop_q      <= estop;
    end
  end

  assign cmd_ready = ~estop;
  assign pwm_data  = {cur_dir_q, cur_spd_q};
  assign busy      = (state_q != StSteady);
  assign at_target = on_target & ~estop_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with STEP_CYCLES=4, DEAD_CYCLES=3. Expected pwm_data
// changes are queued with the cycle they must appear on; a monitor pops and compares them and
// checks that pwm_data holds its last expected value on every other cycle.
module tb_motor_ramp_ctrl;

  localparam int unsigned StepCycles = 4;
  localparam int unsigned DeadCycles = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [2:0] cmd_spd;
  logic       estop;
  logic [3:0] pwm_data;
  logic       busy;
  logic       at_target;

  motor_ramp_ctrl #(
    .STEP_CYCLES(StepCycles),
    .DEAD_CYCLES(DeadCycles)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_spd  (cmd_spd),
    .estop    (estop),
    .pwm_data (pwm_data),
    .busy     (busy),
    .at_target(at_target)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; read on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] val;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] last   = 4'h0;
  bit         mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.at  = c;
    e.val = v;
    sb.push_back(e);
  endtask

  // Called on a falling edge; the command is taken on the next rising edge.
  task automatic send(input logic d, input logic [2:0] s, output int acc);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_spd   = s;
    acc       = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Asserts rst between clock edges, checks outputs before any edge, releases on a falling edge.
  task automatic do_reset();
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_pwm_immediate", pwm_data, 4'h0);
    chk("rst_busy_immediate", busy, 1'b0);
    chk("rst_sb_drained", sb.size(), 0);
    @(negedge clk);
    rst    = 1'b0;
    chk("rst_at_target", at_target, 1'b1);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    last   = 4'h0;
    mon_en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int a, b, c, d, e, f, g, unused;
    exp_t m;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_spd   = 3'd0;
    estop     = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (sb.size() > 0 && sb[0].at == cyc) begin
            m = sb.pop_front();
            chk("pwm_step", pwm_data, m.val);
            last = m.val;
          end else begin
            chk("pwm_hold", pwm_data, last);
          end
        end
      end
    join_none

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_pwm", pwm_data, 4'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_at_target", at_target, 1'b1);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    last   = 4'h0;
    mon_en = 1'b1;

    // 1: ramp 0 -> fwd 3
    send(1'b0, 3'd3, a);
    push(a + 5, 4'h1);
    push(a + 9, 4'h2);
    push(a + 13, 4'h3);
    chk("t1_at_target_after_accept", at_target, 1'b0);
    wait_until(a + 1);
    chk("t1_busy_ramp", busy, 1'b1);
    wait_until(a + 13);
    chk("t1_busy_at_last_step", busy, 1'b1);
    wait_until(a + 14);
    chk("t1_busy_settled", busy, 1'b0);
    chk("t1_at_target", at_target, 1'b1);

    // 2: reversal to rev 2 through DEAD
    send(1'b1, 3'd2, b);
    push(b + 5, 4'h2);
    push(b + 9, 4'h1);
    push(b + 13, 4'h0);
    push(b + 17, 4'h8);
    push(b + 21, 4'h9);
    push(b + 25, 4'hA);
    wait_until(b + 16);
    chk("t2_busy_dead", busy, 1'b1);
    wait_until(b + 26);
    chk("t2_busy_settled", busy, 1'b0);
    chk("t2_at_target", at_target, 1'b1);

    // 3: mid-ramp retarget keeps step_cnt running
    do_reset();
    send(1'b0, 3'd5, c);
    push(c + 5, 4'h1);
    push(c + 9, 4'h2);
    wait_until(c + 9);
    send(1'b0, 3'd1, unused);
    push(c + 13, 4'h1);
    wait_until(c + 13);
    chk("t3_busy_at_step", busy, 1'b1);
    wait_until(c + 14);
    chk("t3_busy_settled", busy, 1'b0);
    chk("t3_at_target", at_target, 1'b1);
    wait_until(c + 18);

    // 4: climb to rev 3, then a 5-cycle estop
    send(1'b1, 3'd3, d);
    push(d + 5, 4'h0);
    push(d + 9, 4'h8);
    push(d + 13, 4'h9);
    push(d + 17, 4'hA);
    push(d + 21, 4'hB);
    wait_until(d + 23);
    chk("t4_steady_before_estop", busy, 1'b0);
    estop = 1'b1;
    e = cyc + 1;
    push(e, 4'h8);
    #1;
    chk("t4_cmd_ready_low", cmd_ready, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_spd   = 3'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t4_cmd_ready_still_low", cmd_ready, 1'b0);
    chk("t4_at_target_estop", at_target, 1'b0);
    chk("t4_busy_estop", busy, 1'b1);
    wait_until(e + 4);
    estop = 1'b0;
    #1;
    chk("t4_cmd_ready_back", cmd_ready, 1'b1);
    wait_until(e + 6);
    chk("t4_busy_dead_count", busy, 1'b1);
    wait_until(e + 7);
    chk("t4_busy_settled", busy, 1'b0);
    chk("t4_at_target_spd0", at_target, 1'b1);
    wait_until(e + 8);

    // 5: async reset mid-ramp
    send(1'b1, 3'd5, f);
    push(f + 5, 4'h9);
    wait_until(f + 5);
    do_reset();

    // 6: back-to-back commands, latest wins
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_spd   = 3'd7;
    @(negedge clk);
    cmd_spd = 3'd2;
    g = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    push(g + 4, 4'h1);
    push(g + 8, 4'h2);
    wait_until(g + 9);
    chk("t6_busy_settled", busy, 1'b0);
    wait_until(g + 14);
    chk("t6_at_target", at_target, 1'b1);
    chk("t6_sb_empty", sb.size(), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
